// File: rtl/ring_freq_counter.sv
// ring_freq_counter
//   Counts the rising edges of a ring oscillator during a gate window of
//   GATE_CYCLES system clocks. Each result is published as an 8-bit count that
//   saturates at 255.
//
//   Ports:
//     clk     in   system clock; all state changes on posedge
//     rst     in   asynchronous, active-high reset
//     en      in   measurement enable, synchronous to clk
//     ring_in in   raw ring-oscillator output, asynchronous to clk
//     bin     out  edge count of the last completed window (saturating)
//     valid   out  one-cycle pulse when bin and ovf update
//     ovf     out  last completed window saturated
//
//   Optional build macro FREQ_CNT_STICKY_OVF_EN:
//     defined   : ovf is sticky across windows and is cleared by rst or by
//                 entering IDLE.
//     undefined : ovf is rewritten at every latch.
module ring_freq_counter #(
  parameter int GATE_CYCLES = 50000,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ring_in,
  output logic [7:0] bin,
  output logic       valid,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic inc);
    if (inc && (cnt != 8'hFF)) begin
      sat_inc = cnt + 8'd1;
    end else begin
      sat_inc = cnt;
    end
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [7:0]             edge_q, edge_d;
  logic                   sat_q, sat_d;
  logic [7:0]             bin_q, bin_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic                   rise;
  logic [7:0]             edge_cnt;
  logic                   sat_cnt;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], ring_in};
    prev_d   = sync_q[SYNC_STAGES-1];
    rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    // Count and saturation as they stand including this cycle's rise, so a
    // rise on the final gate cycle still reaches the published result.
    edge_cnt = sat_inc(edge_q, rise);
    sat_cnt  = sat_q | (rise & (edge_q == 8'hFF));

    state_d  = state_q;
    gate_d   = gate_q;
    edge_d   = edge_q;
    sat_d    = sat_q;
    bin_d    = bin_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        gate_d = '0;
        edge_d = '0;
        sat_d  = 1'b0;
        if (en) begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!en) begin
          // Abort: drop the partial window, keep the last published result.
          state_d = IDLE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
`ifdef FREQ_CNT_STICKY_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          edge_d = edge_cnt;
          sat_d  = sat_cnt;
          gate_d = gate_q + 1'b1;
          if (gate_q == GATE_LAST) begin
            // Result registers load on the edge entering LATCH, so bin/ovf and
            // the valid pulse all appear together during the LATCH cycle.
            state_d = LATCH;
            bin_d   = edge_cnt;
            valid_d = 1'b1;
`ifdef FREQ_CNT_STICKY_OVF_EN
            ovf_d   = ovf_q | sat_cnt;
`else
            ovf_d   = sat_cnt;
`endif
          end
        end
      end

      LATCH: begin
        // Dead cycle: any rise seen here is discarded by the clear.
        gate_d = '0;
        edge_d = '0;
        sat_d  = 1'b0;
        if (en) begin
          state_d = COUNT;
        end else begin
          state_d = IDLE;
`ifdef FREQ_CNT_STICKY_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        gate_d  = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bin   = bin_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench for ring_freq_counter. Instance u_a uses a 100-cycle gate,
// u_b a 1000-cycle gate for the saturation case. Ring inputs are toggled from
// the main sequence every half_x ticks (half_x = 0 holds the level).
module tb_ring_freq_counter;

`ifdef FREQ_CNT_STICKY_OVF_EN
  localparam int STICKY = 1;
`else
  localparam int STICKY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, ring_a, en_b, ring_b;
  logic [7:0] bin_a, bin_b;
  logic       valid_a, valid_b, ovf_a, ovf_b;

  int half_a, half_b, ph_a, ph_b;
  int n_cmp  = 0;
  int n_fail = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  ring_freq_counter #(.GATE_CYCLES(100), .GATE_W(16), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .ring_in(ring_a),
    .bin(bin_a), .valid(valid_a), .ovf(ovf_a)
  );

  ring_freq_counter #(.GATE_CYCLES(1000), .GATE_W(16), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .ring_in(ring_b),
    .bin(bin_b), .valid(valid_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: step to 1 ns after the rising edge, then advance ring patterns.
  task automatic tick();
    @(posedge clk);
    #1;
    if (half_a != 0) begin
      ph_a++;
      if (ph_a >= half_a) begin
        ph_a   = 0;
        ring_a = ~ring_a;
      end
    end
    if (half_b != 0) begin
      ph_b++;
      if (ph_b >= half_b) begin
        ph_b   = 0;
        ring_b = ~ring_b;
      end
    end
  endtask

  // Ticks until the selected valid is seen high, at most max ticks.
  task automatic wait_valid(input bit sel_b, input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((((sel_b ? valid_b : valid_a)) !== 1'b1) && (cnt < max));
  endtask

  initial begin
    rst    = 1'b1;
    en_a   = 1'b0;
    en_b   = 1'b0;
    ring_a = 1'b0;
    ring_b = 1'b0;
    half_a = 0;
    half_b = 0;
    ph_a   = 0;
    ph_b   = 0;

    // Reset state
    repeat (3) tick();
    check("rst_bin", bin_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_ovf", ovf_a, 0);
    #2 rst = 1'b0;
    tick();

    // Period-10 ring, 100-cycle gate: 10 edges per window, 101-cycle period
    en_a   = 1'b1;
    half_a = 5;
    ph_a   = 0;
    wait_valid(1'b0, 300, n);
    check("w1_latency", n, 101);
    check("w1_bin", bin_a, 10);
    check("w1_ovf", ovf_a, 0);
    tick();
    check("w1_pulse_one_cycle", valid_a, 0);
    check("w1_bin_stable", bin_a, 10);
    wait_valid(1'b0, 300, n);
    check("w2_period", n, 100);
    check("w2_bin", bin_a, 10);
    check("w2_ovf", ovf_a, 0);

    // Abort mid-window: no valid, bin holds, restart gives full window
    en_a   = 1'b0;
    half_a = 2;
    ph_a   = 0;
    repeat (10) tick();
    en_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("p4_latency", n, 101);
    check("p4_bin", bin_a, 25);
    repeat (60) tick();
    en_a = 1'b0;
    seen = 0;
    repeat (150) begin
      tick();
      if (valid_a === 1'b1) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_bin_hold", bin_a, 25);
    half_a = 5;
    ph_a   = 0;
    repeat (10) tick();
    en_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("reen_latency", n, 101);
    check("reen_bin", bin_a, 10);

    // Saturation on the 1000-cycle gate, then drop to 50 edges
    en_b   = 1'b1;
    half_b = 1;
    ph_b   = 0;
    wait_valid(1'b1, 1200, n);
    check("sat_latency", n, 1001);
    check("sat_bin", bin_b, 255);
    check("sat_ovf", ovf_b, 1);
    half_b = 10;
    ph_b   = 0;
    wait_valid(1'b1, 1200, n);
    check("mix_period", n, 1001);
    check("mix_ovf", ovf_b, STICKY);
    wait_valid(1'b1, 1200, n);
    check("p20_period", n, 1001);
    check("p20_bin", bin_b, 50);
    check("p20_ovf", ovf_b, STICKY);

    // Asynchronous reset mid-window, between clock edges
    wait_valid(1'b0, 300, n);
    check("pre_rst_bin", bin_a, 10);
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_bin", bin_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_ovf", ovf_a, 0);
    check("arst_bin_b", bin_b, 0);
    en_a   = 1'b0;
    en_b   = 1'b0;
    half_a = 0;
    half_b = 0;
    ring_a = 1'b0;
    ring_b = 1'b0;
    repeat (3) tick();
    check("arst_held_valid", valid_a, 0);
    #2 rst = 1'b0;
    en_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("post_rst_latency", n, 101);
    check("post_rst_bin", bin_a, 0);
    check("post_rst_ovf", ovf_a, 0);

    // Constant-high ring: no edges in the window
    en_a   = 1'b0;
    ring_a = 1'b1;
    repeat (10) tick();
    en_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("const_latency", n, 101);
    check("const_bin", bin_a, 0);
    check("const_ovf", ovf_a, 0);

    // Single rise landing on the final COUNT cycle is counted
    ring_a = 1'b0;
    repeat (98) tick();
    ring_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("last_cycle_latency", n, 3);
    check("last_cycle_bin", bin_a, 1);

    // Single rise landing on the LATCH cycle is dropped
    ring_a = 1'b0;
    repeat (99) tick();
    ring_a = 1'b1;
    wait_valid(1'b0, 300, n);
    check("latch_rise_latency", n, 2);
    check("latch_rise_bin_w1", bin_a, 0);
    wait_valid(1'b0, 300, n);
    check("latch_rise_period", n, 101);
    check("latch_rise_bin_w2", bin_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
